memory: RTL and testbench
=========================

MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of words.
REQ-002 SHALL have parameter WIDTH, default 16, bits per word.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address bits.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port valid_i  input  1  request valid.
REQ-007 SHALL have port wr_rd_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port addr_i  input  ADDR_WIDTH  word address.
REQ-009 SHALL have port wdata_i  input  WIDTH  write data.
REQ-010 SHALL have port ready_o  output  1  accepting requests.
REQ-011 SHALL have port rdata_o  output  WIDTH  registered read data.
REQ-012 SHALL have port rvalid_o  output  1  rdata_o updated this cycle.
REQ-013 SHALL have port wr_cnt_o  output  16  saturating count of accepted writes.
REQ-014 SHALL have port rd_cnt_o  output  16  saturating count of accepted reads.

Function
REQ-015 SHALL treat a request as accepted on a rising edge where valid_i && ready_o.
REQ-016 SHALL drive ready_o high in every cycle after reset is released; no back-pressure, so valid_i implies ready_o in the same cycle.
REQ-017 SHALL, on an accepted write, store wdata_i at addr_i at that edge; the new value is visible to a read accepted at the next edge.
REQ-018 SHALL, on an accepted read, load mem[addr_i] into rdata_o at that edge (1-cycle latency) and pulse rvalid_o high for exactly that following cycle.
REQ-019 SHALL hold rdata_o at its last value when no read is accepted; rvalid_o low.
REQ-020 SHALL perform no array or counter update when valid_i is low.
REQ-021 SHALL ignore addresses >= DEPTH (non-power-of-2 DEPTH): a write is dropped, a read returns all zeros with rvalid_o pulsed; both still count.
REQ-022 SHALL increment wr_cnt_o/rd_cnt_o by 1 per accepted write/read and saturate at 16'hFFFF (no wrap).
REQ-023 SHALL keep rdata_o free of X/Z at all times after reset, because every word is cleared at reset.
REQ-024 SHALL implement a two-state FSM: RESET (ready_o=0) -> ACTIVE on the first edge with rst_i low; ACTIVE -> RESET on any edge with rst_i high.
REQ-025 SHALL back-to-back handle one request per cycle; a read at the edge after a write to the same address returns the written data.

Reset
REQ-026 SHALL, on any edge with rst_i high, including mid-operation: clear all DEPTH words to 0, rdata_o=0, rvalid_o=0, ready_o=0, wr_cnt_o=0, rd_cnt_o=0, state=RESET.
REQ-027 SHALL drop a request presented on an edge with rst_i high; a pending rvalid_o pulse is cancelled.
REQ-028 SHALL assert ready_o in the first cycle following the first edge with rst_i low.

Structure
REQ-029 SHALL place in package mem_pkg: default DEPTH/WIDTH constants, op constants OP_READ=0/OP_WRITE=1, state enum {RESET, ACTIVE}, counter width constant CNT_W=16.
REQ-030 SHALL use sub-module mem_array (clear-on-reset register storage, one write port, one synchronous read port); FSM, handshake and counters live in memory.
REQ-031 SHALL be bindable to the existing memory handshake checker by using the port names clk_i, rst_i, wr_rd_i, valid_i, addr_i, wdata_i, rdata_o, ready_o.

Verification
REQ-032 SHALL cover: reset 3 cycles, release -> ready_o=1 next cycle, rdata_o=0, counters 0.
REQ-033 SHALL cover: write addr 5 data 16'hA5A5, then read addr 5 next cycle -> rdata_o=16'hA5A5 with rvalid_o=1 one cycle after the read.
REQ-034 SHALL cover: read unwritten addr 15 after reset -> rdata_o=16'h0000, never X.
REQ-035 SHALL cover: write addr 3 = 16'h1234, assert rst_i one cycle, read addr 3 -> 16'h0000, wr_cnt_o=0 after reset.
REQ-036 SHALL cover: 65,540 consecutive writes -> wr_cnt_o=16'hFFFF held; rd_cnt_o unchanged.
REQ-037 SHALL cover: checker bound across all scenarios -> zero assertion failures.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the word-addressed memory block.
package mem_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 16;
  localparam int CNT_W     = 16;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic {
    RESET  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Register-based word storage: one write port, one registered read port,
// every word cleared on reset. Addresses at or beyond DEPTH are ignored on
// write and read back as zero.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             in_range;

  assign in_range = ({1'b0, addr_i} < DEPTH_LIM);

  // Next array contents and read register; read sees the pre-write value.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (we_i && in_range) begin
      mem_d[addr_i] = wdata_i;
    end
    if (re_i) begin
      rdata_d = in_range ? mem_q[addr_i] : '0;
    end
  end

  // Storage and read register; reset wins over any request on the same edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the whole array is cleared on reset so reads never return X; this rules out a RAM macro, which is fine at this size.
      mem_q   <= '{default: '0};
      rdata_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory.sv
// Memory front end: RESET/ACTIVE state machine, always-ready handshake,
// read-valid pulse and saturating access counters around mem_array.
module memory
  import mem_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  rvalid_o,
  output logic [CNT_W-1:0]      wr_cnt_o,
  output logic [CNT_W-1:0]      rd_cnt_o
);

  state_e           state_q, state_d;
  logic             rvalid_q, rvalid_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             accept, wr_acc, rd_acc;

  assign accept = valid_i && ready_o;
  assign wr_acc = accept && (wr_rd_i == OP_WRITE);
  assign rd_acc = accept && (wr_rd_i == OP_READ);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave RESET on the first edge without reset, then stay ACTIVE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:   state_d = ACTIVE;
      ACTIVE:  state_d = ACTIVE;
      default: state_d = RESET;
    endcase
  end

  // State outputs: requests are taken in every ACTIVE cycle.
  always_comb begin
    ready_o = (state_q == ACTIVE);
  end

  // Read-valid pulse and saturating counters.
  always_comb begin
    rvalid_d = rd_acc;
    wr_cnt_d = wr_acc ? sat_inc(wr_cnt_q) : wr_cnt_q;
    rd_cnt_d = rd_acc ? sat_inc(rd_cnt_q) : rd_cnt_q;
  end

  // Handshake and counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;

  mem_array #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_acc),
    .re_i    (rd_acc),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o)
  );

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for memory, built with a non-power-of-2 depth so that
// out-of-range addresses are exercised.
module tb_memory;

  localparam int DEPTH = 12;
  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             valid_i = 1'b0;
  logic             wr_rd_i = 1'b0;
  logic [AW-1:0]    addr_i = '0;
  logic [WIDTH-1:0] wdata_i = '0;
  logic             ready_o;
  logic [WIDTH-1:0] rdata_o;
  logic             rvalid_o;
  logic [15:0]      wr_cnt_o;
  logic [15:0]      rd_cnt_o;

  memory #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .wr_rd_i  (wr_rd_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .ready_o  (ready_o),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .wr_cnt_o (wr_cnt_o),
    .rd_cnt_o (rd_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state, updated just after each rising edge.
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [WIDTH-1:0] m_rdata  = '0;
  logic             m_rvalid = 1'b0;
  logic             m_active = 1'b0;
  int               m_wr = 0;
  int               m_rd = 0;
  logic [WIDTH-1:0] exp_q [$];
  bit               started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and advance the model across the edge.
  task automatic cycle(input logic rst, input logic v, input logic wr,
                       input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    bit acc;
    rst_i   = rst;
    valid_i = v;
    wr_rd_i = wr;
    addr_i  = a;
    wdata_i = d;
    @(posedge clk_i);
    acc = v && m_active && !rst;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_wr     = 0;
      m_rd     = 0;
      m_active = 1'b0;
      exp_q.delete();
    end else begin
      m_rvalid = 1'b0;
      if (acc && wr) begin
        if (int'(a) < DEPTH) m_mem[a] = d;
        if (m_wr < 16'hFFFF) m_wr++;
      end else if (acc) begin
        m_rdata  = (int'(a) < DEPTH) ? m_mem[a] : '0;
        m_rvalid = 1'b1;
        exp_q.push_back(m_rdata);
        if (m_rd < 16'hFFFF) m_rd++;
      end
      m_active = 1'b1;
    end
    started = 1'b1;
    #1;
  endtask

  // Monitor: per-cycle model comparison plus scoreboard pop on rvalid_o.
  always @(negedge clk_i) begin
    if (started) begin
      check("ready", 32'(ready_o), 32'(m_active));
      check("rvalid", 32'(rvalid_o), 32'(m_rvalid));
      if (rvalid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rvalid_unexpected: got rvalid=1 expected no pending read at %0t", $time);
        end else begin
          check("rdata_sb", 32'(rdata_o), 32'(exp_q.pop_front()));
        end
      end
      check("rdata_hold", 32'(rdata_o), 32'(m_rdata));
      check("wr_cnt", 32'(wr_cnt_o), 32'(m_wr));
      check("rd_cnt", 32'(rd_cnt_o), 32'(m_rd));
    end
  end

  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;

    // Reset for three cycles, then release.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk_i);
    check("rst_ready_low", 32'(ready_o), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk_i);
    check("rel_ready", 32'(ready_o), 32'd1);
    check("rel_rdata", 32'(rdata_o), 32'h0);
    check("rel_wr_cnt", 32'(wr_cnt_o), 32'd0);
    check("rel_rd_cnt", 32'(rd_cnt_o), 32'd0);

    // Write then read back at the next edge.
    cycle(1'b0, 1'b1, 1'b1, 4'd5, 16'hA5A5);
    cycle(1'b0, 1'b1, 1'b0, 4'd5, '0);
    @(negedge clk_i);
    check("rd5_rvalid", 32'(rvalid_o), 32'd1);
    check("rd5_rdata", 32'(rdata_o), 32'hA5A5);

    // Address 15 is beyond DEPTH: write dropped, read returns zero.
    cycle(1'b0, 1'b1, 1'b1, 4'd15, 16'hFFFF);
    cycle(1'b0, 1'b1, 1'b0, 4'd15, '0);
    @(negedge clk_i);
    check("rd15_rdata", 32'(rdata_o), 32'h0);
    check("rd15_wr_cnt", 32'(wr_cnt_o), 32'd2);

    // Mid-operation reset clears storage and counters; read during reset is dropped.
    cycle(1'b0, 1'b1, 1'b1, 4'd3, 16'h1234);
    cycle(1'b1, 1'b1, 1'b0, 4'd3, '0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk_i);
    check("rst_wr_cnt", 32'(wr_cnt_o), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 4'd3, '0);
    @(negedge clk_i);
    check("rd3_rdata", 32'(rdata_o), 32'h0);
    check("rd3_rvalid", 32'(rvalid_o), 32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom), 4'($urandom_range(0, 15)), 16'($urandom));
    end

    // Counter saturation: a few reads, then more writes than the counter can hold.
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 4'(i), '0);
    for (int i = 0; i < 65540; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom));
    end
    @(negedge clk_i);
    check("sat_wr_cnt", 32'(wr_cnt_o), 32'hFFFF);
    check("sat_rd_cnt", 32'(rd_cnt_o), 32'd3);
    cycle(1'b0, 1'b1, 1'b0, 4'd0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk_i);
    check("sat_wr_hold", 32'(wr_cnt_o), 32'hFFFF);
    check("post_rd_cnt", 32'(rd_cnt_o), 32'd4);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
